rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Shares the register file's single write port (`we3`/`ad3`/`wd3`) between two writeback requesters: the ALU result path and the load unit. Each requester has a valid/ready handshake into a one-entry holding slot. Each cycle the block grants one full slot onto the write port and preserves program order when both slots target the same register. It also publishes a pending-write bitmask for hazard logic. It sits between the execute/load stages and the register file.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 5: register index width.
- `DATA_WIDTH`, default 32: register data width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_ready`  out  1  ALU slot can accept this cycle.
- `alu_rd`  in  ADDRESS_WIDTH  ALU destination register.
- `alu_data`  in  DATA_WIDTH  ALU result.
- `ld_valid`  in  1  load writeback request.
- `ld_ready`  out  1  load slot can accept this cycle.
- `ld_rd`  in  ADDRESS_WIDTH  load destination register.
- `ld_data`  in  DATA_WIDTH  load data.
- `we3`  out  1  register file write enable.
- `ad3`  out  ADDRESS_WIDTH  register file write address.
- `wd3`  out  DATA_WIDTH  register file write data.
- `pending`  out  2**ADDRESS_WIDTH  bit r set while a buffered write to register r is uncommitted.

## Operation
- Slot state per requester: `full`, `rd`, `data`. Arbiter state: `age` (1 = load slot is older), `rr_last`.
- Accept occurs when `X_valid && X_ready`. It loads the slot and sets `full` at the next edge.
- `X_ready = !full_X || grant_X`. A granted slot can be refilled in the same cycle, so a requester can sustain one write per cycle.
- Writes to x0: a request with `rd == 0` is accepted and discarded. It never fills the slot and never asserts `we3`.
- Grant selection, among full slots only:
  - Both full with equal `rd`: grant the older slot, as indicated by `age`.
  - Both full with different `rd`: grant per the Configuration section.
  - One full: grant that slot.
- Age rule:
  - When the load slot fills while the ALU slot is already full, or vice versa, the already-full slot is older.
  - Simultaneous fill: the load slot is older.
- Write port: `we3 = |grant`. `ad3`/`wd3` come from the granted slot, and are 0 when there is no grant. These outputs are combinational from slot registers only, with no path from the request inputs.
- `pending[r] = (full_alu && rd_alu==r) | (full_ld && rd_ld==r)`. `pending[0]` is always 0.
- Reset: both slots empty, `age=0`, `rr_last=ALU`. Consequently `we3=0`, `ad3=0`, `wd3=0`, `pending=0`, `alu_ready=ld_ready=1` from the first cycle after reset.
- Reset asserted mid-operation drops buffered writes. No `we3` pulse occurs in the cycle `rst` is high.

## Timing
- Latency: a request accepted at edge E appears on `we3` in the cycle after E (at the earliest). The register is updated at the edge E+1.
- A blocked slot holds its contents unchanged until granted. The requester keeps `X_ready` low.
- Maximum stall for a slot is one cycle when both slots are continuously full with different `rd`, in RR mode.

## Configuration
- `RF_WB_ARB_RR_EN` defined: round-robin arbitration between different-`rd` slots. The slot not granted last (`rr_last`) wins, and `rr_last` updates on every grant.
- Undefined: fixed priority, load over ALU. `rr_last` is not implemented. The equal-`rd` age rule applies in both modes.

## Structure
- Package `rf_wb_pkg`:
  - Default `ADDRESS_WIDTH`/`DATA_WIDTH` constants.
  - `wb_req_t` struct {rd, data}.
  - `wb_src_e` enum {WB_SRC_ALU, WB_SRC_LD}.
- Sub-module `wb_slot`: one-entry buffer with x0 discard. Instantiated twice. Outputs `full`, `rd`, `data`, `ready`. Input `grant`.

## Test plan
- Reset, then ALU rd=5 data=0xDEADBEEF in one cycle → next cycle `we3=1`, `ad3=5`, `wd3=0xDEADBEEF`. `pending[5]=1` in that cycle and 0 after.
- ALU rd=0 data=0x1 → accepted (`alu_ready=1`), `we3` never asserted, `pending=0`.
- Both valid in the same cycle with rd=7, ld=0x11, alu=0x22 → cycle 1 writes 0x11, cycle 2 writes 0x22. Register 7 finally holds 0x22.
- Both continuously valid with rd 3 and 4:
  - RR build: writes alternate LD, ALU, LD, ...
  - Fixed build: load wins each contested cycle, and `alu_ready` stays 0 while load streams.
- ALU streams rd=1,2,3 on back-to-back cycles with load idle → `we3` high for 3 consecutive cycles and `alu_ready` stays 1.
- Both slots full, `rst` pulsed for one cycle → `we3=0` during reset, `pending=0` after, and no stale write is issued afterwards.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// The RF_WB_ARB_RR_EN macro is consumed by rf_wb_arbiter, not by this package.
package rf_wb_pkg;

   localparam int RF_WB_ADDRESS_WIDTH = 5;
   localparam int RF_WB_DATA_WIDTH    = 32;

   typedef struct packed {
      logic [RF_WB_ADDRESS_WIDTH-1:0] rd;
      logic [RF_WB_DATA_WIDTH-1:0]    data;
   } wb_req_t;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LD  = 1'b1
   } wb_src_e;

   // age=1 means the load slot filled first
   function automatic wb_src_e older_src(input logic age);
      if (age) begin
         return WB_SRC_LD;
      end else begin
         return WB_SRC_ALU;
      end
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Requester handshakes plus register-file write port and pending mask.
interface rf_wb_arbiter_if
   import rf_wb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = RF_WB_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = RF_WB_DATA_WIDTH
) ();

   localparam int NREG = 2 ** ADDRESS_WIDTH;

   logic                     alu_valid;
   logic                     alu_ready;
   logic [ADDRESS_WIDTH-1:0] alu_rd;
   logic [DATA_WIDTH-1:0]    alu_data;
   logic                     ld_valid;
   logic                     ld_ready;
   logic [ADDRESS_WIDTH-1:0] ld_rd;
   logic [DATA_WIDTH-1:0]    ld_data;
   logic                     we3;
   logic [ADDRESS_WIDTH-1:0] ad3;
   logic [DATA_WIDTH-1:0]    wd3;
   logic [NREG-1:0]          pending;

   modport master (
      output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
      input  alu_ready, ld_ready, we3, ad3, wd3, pending
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
      output alu_ready, ld_ready, we3, ad3, wd3, pending
   );

endinterface

// File: rtl/rf_wb_arbiter_slot.sv
// wb_slot: one-entry writeback holding buffer; writes to x0 are accepted and dropped.
module wb_slot #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [ADDRESS_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     grant,
   output logic                     ready,
   output logic                     full,
   output logic [ADDRESS_WIDTH-1:0] rd,
   output logic [DATA_WIDTH-1:0]    data,
   output logic                     fill
);

   logic                     full_r;
   logic [ADDRESS_WIDTH-1:0] rd_r;
   logic [DATA_WIDTH-1:0]    data_r;

   // A slot being drained this cycle may be refilled at the same edge
   assign ready = !full_r || grant;
   assign fill  = in_valid && ready && (in_rd != {ADDRESS_WIDTH{1'b0}});

   // Slot register: refill wins over drain, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r <= 1'b0;
         rd_r   <= {ADDRESS_WIDTH{1'b0}};
         data_r <= {DATA_WIDTH{1'b0}};
      end else if (fill) begin
         full_r <= 1'b1;
         rd_r   <= in_rd;
         data_r <= in_data;
      end else if (grant) begin
         full_r <= 1'b0;
      end else begin
         full_r <= full_r;
      end
   end

   assign full = full_r;
   assign rd   = rd_r;
   assign data = data_r;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Define RF_WB_ARB_RR_EN for round-robin between different-rd slots; default is load-over-ALU.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = RF_WB_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = RF_WB_DATA_WIDTH
) (
   input logic            clk,
   input logic            rst,
   rf_wb_arbiter_if.slave bus
);

   localparam int              NREG    = 2 ** ADDRESS_WIDTH;
   localparam logic [NREG-1:0] REG_ONE = {{(NREG-1){1'b0}}, 1'b1};

   logic                     alu_ready_s, alu_full_s, alu_fill_s;
   logic [ADDRESS_WIDTH-1:0] alu_rd_s;
   logic [DATA_WIDTH-1:0]    alu_data_s;
   logic                     ld_ready_s, ld_full_s, ld_fill_s;
   logic [ADDRESS_WIDTH-1:0] ld_rd_s;
   logic [DATA_WIDTH-1:0]    ld_data_s;
   logic                     grant_alu_s, grant_ld_s;
   logic                     sel_valid_s;
   wb_src_e                  sel_src_s;
   logic                     age_r;
   logic [ADDRESS_WIDTH-1:0] ad3_s;
   logic [DATA_WIDTH-1:0]    wd3_s;
   logic [NREG-1:0]          alu_mask_s, ld_mask_s;

   wb_slot #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_alu_slot (
      .clk(clk), .rst(rst),
      .in_valid(bus.alu_valid), .in_rd(bus.alu_rd), .in_data(bus.alu_data),
      .grant(grant_alu_s), .ready(alu_ready_s), .full(alu_full_s),
      .rd(alu_rd_s), .data(alu_data_s), .fill(alu_fill_s)
   );

   wb_slot #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ld_slot (
      .clk(clk), .rst(rst),
      .in_valid(bus.ld_valid), .in_rd(bus.ld_rd), .in_data(bus.ld_data),
      .grant(grant_ld_s), .ready(ld_ready_s), .full(ld_full_s),
      .rd(ld_rd_s), .data(ld_data_s), .fill(ld_fill_s)
   );

`ifdef RF_WB_ARB_RR_EN
   wb_src_e rr_last_r;

   // Remember the most recently granted source
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_r <= WB_SRC_ALU;
      end else if (sel_valid_s) begin
         rr_last_r <= sel_src_s;
      end else begin
         rr_last_r <= rr_last_r;
      end
   end
`endif

   // Grant selection; nothing is granted while rst is high so no write leaks out
   always_comb begin
      sel_valid_s = 1'b0;
      sel_src_s   = WB_SRC_ALU;
      if (rst) begin
         sel_valid_s = 1'b0;
      end else if (alu_full_s && ld_full_s) begin
         sel_valid_s = 1'b1;
         if (alu_rd_s == ld_rd_s) begin
            sel_src_s = older_src(age_r);
         end else begin
`ifdef RF_WB_ARB_RR_EN
            sel_src_s = (rr_last_r == WB_SRC_ALU) ? WB_SRC_LD : WB_SRC_ALU;
`else
            sel_src_s = WB_SRC_LD;
`endif
         end
      end else if (ld_full_s) begin
         sel_valid_s = 1'b1;
         sel_src_s   = WB_SRC_LD;
      end else if (alu_full_s) begin
         sel_valid_s = 1'b1;
         sel_src_s   = WB_SRC_ALU;
      end else begin
         sel_valid_s = 1'b0;
      end
   end

   assign grant_alu_s = sel_valid_s && (sel_src_s == WB_SRC_ALU);
   assign grant_ld_s  = sel_valid_s && (sel_src_s == WB_SRC_LD);

   // Age: a slot that stays full while the other fills is older; a tie makes load older
   always_ff @(posedge clk) begin
      if (rst) begin
         age_r <= 1'b0;
      end else if (ld_fill_s && alu_fill_s) begin
         age_r <= 1'b1;
      end else if (ld_fill_s && alu_full_s && !grant_alu_s) begin
         age_r <= 1'b0;
      end else if (alu_fill_s && ld_full_s && !grant_ld_s) begin
         age_r <= 1'b1;
      end else begin
         age_r <= age_r;
      end
   end

   // Write-port mux driven purely from slot registers
   always_comb begin
      ad3_s = {ADDRESS_WIDTH{1'b0}};
      wd3_s = {DATA_WIDTH{1'b0}};
      case ({grant_ld_s, grant_alu_s})
         2'b01: begin
            ad3_s = alu_rd_s;
            wd3_s = alu_data_s;
         end
         2'b10: begin
            ad3_s = ld_rd_s;
            wd3_s = ld_data_s;
         end
         default: begin
            ad3_s = {ADDRESS_WIDTH{1'b0}};
            wd3_s = {DATA_WIDTH{1'b0}};
         end
      endcase
   end

   assign alu_mask_s = alu_full_s ? (REG_ONE << alu_rd_s) : {NREG{1'b0}};
   assign ld_mask_s  = ld_full_s  ? (REG_ONE << ld_rd_s)  : {NREG{1'b0}};

   assign bus.alu_ready = alu_ready_s;
   assign bus.ld_ready  = ld_ready_s;
   assign bus.we3       = sel_valid_s;
   assign bus.ad3       = ad3_s;
   assign bus.wd3       = wd3_s;
   assign bus.pending   = (alu_mask_s | ld_mask_s) & ~REG_ONE;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: per-cycle vector table plus a write scoreboard.
module tb_rf_wb_arbiter;
   import rf_wb_pkg::*;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rf_wb_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   rf_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic            r;
      logic            av;
      logic [AW-1:0]   ard;
      logic [DW-1:0]   adat;
      logic            lv;
      logic [AW-1:0]   lrd;
      logic [DW-1:0]   ldat;
      logic            ewe;
      logic [AW-1:0]   ead;
      logic [DW-1:0]   ewd;
      logic            ear;
      logic            elr;
      logic [NREG-1:0] epend;
   } vec_t;

   vec_t    tbl[$];
   wb_req_t alu_q[$];
   wb_req_t ld_q[$];
   int      checks = 0;
   int      errors = 0;

   function automatic logic [NREG-1:0] pb(input int n);
      logic [NREG-1:0] one;
      one = 32'd1;
      return one << n;
   endfunction

   function automatic vec_t mk(input logic r, input logic av, input int ard, input logic [31:0] adat,
                               input logic lv, input int lrd, input logic [31:0] ldat,
                               input logic ewe, input int ead, input logic [31:0] ewd,
                               input logic ear, input logic elr, input logic [31:0] epend);
      vec_t v;
      v.r = r;     v.av = av;   v.ard = AW'(ard);  v.adat = adat;
      v.lv = lv;   v.lrd = AW'(lrd); v.ldat = ldat;
      v.ewe = ewe; v.ead = AW'(ead); v.ewd = ewd;
      v.ear = ear; v.elr = elr; v.epend = epend;
      return v;
   endfunction

   function automatic vec_t idle(input logic ewe, input int ead, input logic [31:0] ewd,
                                 input logic ear, input logic elr, input logic [31:0] epend);
      return mk(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, ewe, ead, ewd, ear, elr, epend);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      wb_req_t req;
      rst           = v.r;
      bus.alu_valid = v.av;  bus.alu_rd = v.ard; bus.alu_data = v.adat;
      bus.ld_valid  = v.lv;  bus.ld_rd  = v.lrd; bus.ld_data  = v.ldat;
      @(negedge clk);
      chk($sformatf("row%0d_we3", idx),       64'(bus.we3),       64'(v.ewe));
      chk($sformatf("row%0d_ad3", idx),       64'(bus.ad3),       64'(v.ead));
      chk($sformatf("row%0d_wd3", idx),       64'(bus.wd3),       64'(v.ewd));
      chk($sformatf("row%0d_alu_ready", idx), 64'(bus.alu_ready), 64'(v.ear));
      chk($sformatf("row%0d_ld_ready", idx),  64'(bus.ld_ready),  64'(v.elr));
      chk($sformatf("row%0d_pending", idx),   64'(bus.pending),   64'(v.epend));
      // Scoreboard: every write must be the head of one source's in-order queue
      if (bus.we3) begin
         checks++;
         if (alu_q.size() > 0 && alu_q[0].rd == bus.ad3 && alu_q[0].data == bus.wd3) begin
            void'(alu_q.pop_front());
         end else if (ld_q.size() > 0 && ld_q[0].rd == bus.ad3 && ld_q[0].data == bus.wd3) begin
            void'(ld_q.pop_front());
         end else begin
            errors++;
            $display("FAIL row%0d_sb_write actual=%0h:%0h required=head of a pending write queue",
                     idx, bus.ad3, bus.wd3);
         end
      end
      if (v.r) begin
         alu_q.delete();
         ld_q.delete();
      end else begin
         if (v.av && bus.alu_ready && v.ard != 5'd0) begin
            req.rd = v.ard; req.data = v.adat; alu_q.push_back(req);
         end
         if (v.lv && bus.ld_ready && v.lrd != 5'd0) begin
            req.rd = v.lrd; req.data = v.ldat; ld_q.push_back(req);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] both;
      rst = 1'b1;
      bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'h0;
      bus.ld_valid  = 1'b0; bus.ld_rd  = 5'd0; bus.ld_data  = 32'h0;
      repeat (2) @(posedge clk);
      #1;

      // Single ALU write, then x0 discard
      tbl.push_back(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(mk(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(idle(1'b1, 5, 32'hDEADBEEF, 1'b1, 1'b1, pb(5)));
      tbl.push_back(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(mk(1'b0, 1'b1, 0, 32'h1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      // Simultaneous fill, same rd: load first
      tbl.push_back(mk(1'b0, 1'b1, 7, 32'h22, 1'b1, 7, 32'h11, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(idle(1'b1, 7, 32'h11, 1'b0, 1'b1, pb(7)));
      tbl.push_back(idle(1'b1, 7, 32'h22, 1'b1, 1'b1, pb(7)));
      tbl.push_back(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      // ALU blocked, then load refills with ALU's rd: ALU is older and must go first
      tbl.push_back(mk(1'b0, 1'b1, 10, 32'hA0, 1'b1, 9, 32'h90, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(mk(1'b0, 1'b0, 0, 32'h0, 1'b1, 10, 32'hB0, 1'b1, 9, 32'h90, 1'b0, 1'b1, pb(9) | pb(10)));
      tbl.push_back(idle(1'b1, 10, 32'hA0, 1'b1, 1'b0, pb(10)));
      tbl.push_back(idle(1'b1, 10, 32'hB0, 1'b1, 1'b1, pb(10)));
      tbl.push_back(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      // ALU back-to-back stream
      tbl.push_back(mk(1'b0, 1'b1, 1, 32'h101, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(mk(1'b0, 1'b1, 2, 32'h102, 1'b0, 0, 32'h0, 1'b1, 1, 32'h101, 1'b1, 1'b1, pb(1)));
      tbl.push_back(mk(1'b0, 1'b1, 3, 32'h103, 1'b0, 0, 32'h0, 1'b1, 2, 32'h102, 1'b1, 1'b1, pb(2)));
      tbl.push_back(idle(1'b1, 3, 32'h103, 1'b1, 1'b1, pb(3)));
      tbl.push_back(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      // Reset with both slots full
      tbl.push_back(mk(1'b0, 1'b1, 12, 32'hC0, 1'b1, 13, 32'hD0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0, pb(12) | pb(13)));
      tbl.push_back(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));
      tbl.push_back(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0));

      foreach (tbl[i]) apply(tbl[i], i);

      // Contested stream: ld rd3 vs alu rd4, both valid for 8 cycles then drain
      both = pb(3) | pb(4);
      apply(mk(1'b0, 1'b1, 4, 32'h44, 1'b1, 3, 32'h33, 1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0), 100);
      for (int k = 1; k < 8; k++) begin
`ifdef RF_WB_ARB_RR_EN
         if (k % 2 == 1)
            apply(mk(1'b0, 1'b1, 4, 32'h44, 1'b1, 3, 32'h33, 1'b1, 3, 32'h33, 1'b0, 1'b1, both), 100 + k);
         else
            apply(mk(1'b0, 1'b1, 4, 32'h44, 1'b1, 3, 32'h33, 1'b1, 4, 32'h44, 1'b1, 1'b0, both), 100 + k);
`else
         apply(mk(1'b0, 1'b1, 4, 32'h44, 1'b1, 3, 32'h33, 1'b1, 3, 32'h33, 1'b0, 1'b1, both), 100 + k);
`endif
      end
`ifdef RF_WB_ARB_RR_EN
      apply(idle(1'b1, 4, 32'h44, 1'b1, 1'b0, both), 108);
      apply(idle(1'b1, 3, 32'h33, 1'b1, 1'b1, pb(3)), 109);
`else
      apply(idle(1'b1, 3, 32'h33, 1'b0, 1'b1, both), 108);
      apply(idle(1'b1, 4, 32'h44, 1'b1, 1'b1, pb(4)), 109);
`endif
      apply(idle(1'b0, 0, 32'h0, 1'b1, 1'b1, 32'h0), 110);

      chk("sb_drain_alu", 64'(alu_q.size()), 64'd0);
      chk("sb_drain_ld",  64'(ld_q.size()),  64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
